// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 4-bit ALU: request FIFO, settle-window FSM and result holding register.
// Optional ALU_ISSUE_STATS_EN adds saturating op/carry counters on the result handshake.
module alu_issue_ctrl #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [1:0] in_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic       alu_c,
    input  logic [3:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [4:0] res_data,
    output logic [3:0] res_a,
    output logic [3:0] res_b,
    output logic [1:0] res_op,
    output logic       busy
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [15:0] carry_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    req_t          head;
    state_t        state;
    logic [SW-1:0] settle_cnt;

    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    // No pass-through when full: a same-cycle pop does not make room for the offer.
    assign in_ready   = !fifo_full && !rst;
    assign push       = in_valid && in_ready;
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == HOLD) && res_ready));
    assign head       = mem[rd_ptr];
    assign busy       = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_op};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A pop always loads the ALU lines and the echo shadow together, from IDLE or back-to-back from HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_a      <= '0;
            res_b      <= '0;
            res_op     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a      <= head.a;
                        alu_b      <= head.b;
                        alu_op     <= head.op;
                        res_a      <= head.a;
                        res_b      <= head.b;
                        res_op     <= head.op;
                        settle_cnt <= SW'(SETTLE_CYCLES);
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SW'(1)) begin
                        res_data   <= {alu_c, alu_out};
                        res_valid  <= 1'b1;
                        settle_cnt <= '0;
                        state      <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop) begin
                            alu_a      <= head.a;
                            alu_b      <= head.b;
                            alu_op     <= head.op;
                            res_a      <= head.a;
                            res_b      <= head.b;
                            res_op     <= head.op;
                            settle_cnt <= SW'(SETTLE_CYCLES);
                            state      <= SETTLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic res_fire;

    assign res_fire = res_valid && res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count    <= '0;
            carry_count <= '0;
        end else if (res_fire) begin
            if (op_count != 16'hFFFF) begin
                op_count <= op_count + 16'd1;
            end
            if (res_data[4] && (carry_count != 16'hFFFF)) begin
                carry_count <= carry_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random traffic against an in-order queue model
// of accepted requests; a simple behavioural ALU drives alu_c/alu_out.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
    } req_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [1:0] in_op = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic       alu_c;
    logic [3:0] alu_out;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [4:0] res_data;
    logic [3:0] res_a;
    logic [3:0] res_b;
    logic [1:0] res_op;
    logic       busy;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] op_count;
    logic [15:0] carry_count;
`endif

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   n_results    = 0;
    int   cyc          = 0;
    req_t exp_q[$];
    int   hs_cycles[$];
    logic       prev_hold = 1'b0;
    logic [4:0] prev_data = '0;
    logic [9:0] prev_echo = '0;

    // Behavioural ALU: ADD, SUB (borrow in bit 4), AND, OR.
    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign {alu_c, alu_out} = alu_model(alu_a, alu_b, alu_op);

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_c      (alu_c),
        .alu_out    (alu_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_a      (res_a),
        .res_b      (res_b),
        .res_op     (res_op),
        .busy       (busy)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .op_count   (op_count),
        .carry_count(carry_count)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, score the handshakes that the next rising edge will take.
    task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] op, input logic rr, output logic acc);
        req_t e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        res_ready = rr;
        #1;
        if (prev_hold) begin
            checkOutput("hold_valid", 32'(res_valid), 32'd1);
            checkOutput("hold_data", 32'(res_data), 32'(prev_data));
            checkOutput("hold_echo", 32'({res_a, res_b, res_op}), 32'(prev_echo));
        end
        if (res_valid) begin
            checkOutput("alu_lines_match_echo", 32'({alu_a, alu_b, alu_op}), 32'({res_a, res_b, res_op}));
        end
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back('{a: a, b: b, op: op});
        end
        if (res_valid && rr) begin
            hs_cycles.push_back(cyc);
            n_results++;
            checkOutput("result_was_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("res_echo", 32'({res_a, res_b, res_op}), 32'({e.a, e.b, e.op}));
                checkOutput("res_data", 32'(res_data), 32'(alu_model(e.a, e.b, e.op)));
            end
        end
        prev_hold = res_valid && !rr;
        prev_data = res_data;
        prev_echo = {res_a, res_b, res_op};
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        logic dummy;
        applyStimulus(1'b0, 4'h0, 4'h0, 2'd0, rr, dummy);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() > 0 || res_valid) && k < 100) begin
            idle(1'b1);
            k++;
        end
        checkOutput(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic       acc;
        int         k;
        int         i;
        int         r0;
        logic [3:0] sa [8];
        logic [3:0] sb [8];
        logic [1:0] so [8];

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_outputs", 32'({res_valid, alu_a, alu_b, alu_op, res_data, res_a, res_b, res_op, busy}), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Single request, latency and data
        applyStimulus(1'b1, 4'hF, 4'h1, 2'd0, 1'b1, acc);
        checkOutput("single_accept", 32'(acc), 32'd1);
        k = 0;
        while (!res_valid && k < 20) begin
            idle(1'b1);
            k++;
        end
        checkOutput("single_latency", 32'(k), 32'd2);
        checkOutput("single_data", 32'(res_data), 32'h10);
        checkOutput("single_echo", 32'({res_a, res_b, res_op}), 32'({4'hF, 4'h1, 2'd0}));
        idle(1'b1);
        idle(1'b1);
        checkOutput("single_busy_clear", 32'(busy), 32'd0);

        // Fill with results stalled: five accepted, sixth refused
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0, acc);
            checkOutput("fill_accept", 32'(acc), 32'(j < 5));
        end
        r0 = n_results;
        idle(1'b0);
        drain("fill_drain_empty");
        checkOutput("fill_result_count", 32'(n_results - r0), 32'd5);

        // Back-to-back stream of 8
        for (int j = 0; j < 8; j++) begin
            sa[j] = 4'($urandom);
            sb[j] = 4'($urandom);
            so[j] = 2'($urandom);
        end
        hs_cycles.delete();
        i = 0;
        k = 0;
        while ((i < 8 || exp_q.size() > 0) && k < 100) begin
            acc = 1'b0;
            if (i < 8) begin
                applyStimulus(1'b1, sa[i], sb[i], so[i], 1'b1, acc);
            end else begin
                idle(1'b1);
            end
            if (acc) begin
                i++;
            end
            k++;
        end
        checkOutput("stream_count", 32'(hs_cycles.size()), 32'd8);
        for (int j = 1; j < hs_cycles.size(); j++) begin
            checkOutput("stream_spacing", 32'(hs_cycles[j] - hs_cycles[j-1]), 32'd2);
        end
        idle(1'b1);

        // Reset while a request is settling with three queued
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0, acc);
            checkOutput("rst_fill_accept", 32'(acc), 32'd1);
        end
        applyStimulus(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1, acc);
        checkOutput("rst_fill_accept", 32'(acc), 32'd1);
        checkOutput("rst_pre_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_mid_outputs", 32'({res_valid, alu_a, alu_b, alu_op, res_data, res_a, res_b, res_op, busy}), 32'd0);
        exp_q.delete();
        prev_hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            idle(1'b1);
            checkOutput("rst_no_result", 32'({res_valid, busy}), 32'd0);
        end

`ifdef ALU_ISSUE_STATS_EN
        applyStimulus(1'b1, 4'hF, 4'h1, 2'd0, 1'b1, acc);
        applyStimulus(1'b1, 4'h2, 4'h3, 2'd0, 1'b1, acc);
        applyStimulus(1'b1, 4'h8, 4'h8, 2'd0, 1'b1, acc);
        drain("stats_drain_empty");
        checkOutput("stats_op_count", 32'(op_count), 32'd3);
        checkOutput("stats_carry_count", 32'(carry_count), 32'd2);
`endif

        // Offer while full in the same cycle as a result pop
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0, acc);
            checkOutput("full_fill_accept", 32'(acc), 32'd1);
        end
        checkOutput("full_res_valid", 32'(res_valid), 32'd1);
        applyStimulus(1'b1, 4'hA, 4'h5, 2'd3, 1'b1, acc);
        checkOutput("full_pop_refused", 32'(acc), 32'd0);
        checkOutput("full_pop_in_ready_after", 32'(in_ready), 32'd1);
        r0 = n_results;
        drain("full_drain_empty");
        checkOutput("full_result_count", 32'(n_results - r0), 32'd4);

        // Random traffic
        for (int j = 0; j < 300; j++) begin
            applyStimulus(1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
                          ($urandom_range(0, 3) != 0), acc);
        end
        drain("random_drain_empty");
        idle(1'b1);
        checkOutput("random_busy_clear", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
